rr_stream_mux: RTL

//  N-channel, W-bit streaming multiplexer; parametrised successor to the combinational 2/4/8:1 muxes.

---
 rtl/rr_stream_mux_pkg.sv | 18 +
 rtl/rr_stream_mux_arbiter.sv | 35 +++
 rtl/rr_stream_mux.sv | 100 ++++++++++
 3 files changed

// File: rtl/rr_stream_mux_pkg.sv
// Shared definitions for the round-robin stream multiplexer: mode encodings
// and a ceiling-log2 helper used to size channel indices.
package rr_stream_mux_pkg;

    localparam logic MODE_RR    = 1'b0;
    localparam logic MODE_FIXED = 1'b1;

    // Counts the powers of two below value, which equals ceil(log2(value)).
    function automatic int clog2(input int value);
        int result;
        result = 0;
        for (int i = 0; i < 31; i++) begin
            result = result + (((32'sd1 <<< i) < value) ? 1 : 0);
        end
        return result;
    endfunction

endpackage

// File: rtl/rr_stream_mux_arbiter.sv
// Rotating-priority arbiter: one-hot grant of the first request at or above
// ptr, wrapping past the top channel back to channel 0.
module rr_arbiter
    import rr_stream_mux_pkg::*;
#(
    parameter  int N_CH  = 4,
    localparam int SEL_W = clog2(N_CH)
) (
    input  logic [N_CH-1:0]  req,
    input  logic [SEL_W-1:0] ptr,
    output logic [N_CH-1:0]  grant
);

    logic [N_CH-1:0]   mask_s;
    logic [2*N_CH-1:0] dbl_s;
    logic [2*N_CH-1:0] gnt2_s;
    logic              found_s;

    // Lower half holds requests at/above ptr, upper half the full set for the wrap.
    always_comb begin
        mask_s  = {N_CH{1'b0}};
        gnt2_s  = {(2*N_CH){1'b0}};
        found_s = 1'b0;
        for (int i = 0; i < N_CH; i++) begin
            mask_s[i] = (i >= int'(ptr));
        end
        dbl_s = {req, req & mask_s};
        for (int i = 0; i < 2*N_CH; i++) begin
            gnt2_s[i] = dbl_s[i] & ~found_s;
            found_s   = found_s | dbl_s[i];
        end
        grant = gnt2_s[N_CH-1:0] | gnt2_s[2*N_CH-1:N_CH];
    end

endmodule

// File: rtl/rr_stream_mux.sv
// N-channel valid/ready stream multiplexer with round-robin or fixed channel
// selection feeding a single registered output slot tagged with its source.
module rr_stream_mux
    import rr_stream_mux_pkg::*;
#(
    parameter  int N_CH  = 4,
    parameter  int W     = 8,
    localparam int SEL_W = clog2(N_CH)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [N_CH*W-1:0] in_data,
    input  logic [N_CH-1:0]   in_valid,
    output logic [N_CH-1:0]   in_ready,
    input  logic              mode,
    input  logic [SEL_W-1:0]  sel,
    output logic [W-1:0]      out_data,
    output logic [SEL_W-1:0]  out_ch,
    output logic              out_valid,
    input  logic              out_ready
);

    logic [W-1:0]     out_data_r;
    logic [SEL_W-1:0] out_ch_r;
    logic             out_valid_r;
    logic [SEL_W-1:0] ptr_r;

    logic             load_s;
    logic [N_CH-1:0]  req_s;
    logic [N_CH-1:0]  grant_s;
    logic [N_CH-1:0]  in_ready_s;
    logic             xfer_s;
    logic [SEL_W-1:0] gidx_s;
    logic [W-1:0]     gdata_s;

    // Request vector; in fixed mode an out-of-range sel matches no channel.
    always_comb begin
        req_s = {N_CH{1'b0}};
        if (mode == MODE_FIXED) begin
            for (int i = 0; i < N_CH; i++) begin
                req_s[i] = in_valid[i] & (int'(sel) == i);
            end
        end else begin
            req_s = in_valid;
        end
    end

    rr_arbiter #(.N_CH(N_CH)) u_arbiter (
        .req   (req_s),
        .ptr   (ptr_r),
        .grant (grant_s)
    );

    // Handshake: the slot can take a word when empty or being drained this cycle.
    always_comb begin
        load_s     = ~out_valid_r | out_ready;
        in_ready_s = {N_CH{1'b0}};
        if (rst) begin
            in_ready_s = {N_CH{1'b0}};
        end else begin
            in_ready_s = grant_s & {N_CH{load_s}};
        end
        xfer_s = |(in_ready_s & in_valid);
    end

    // Encode the one-hot grant into an index and select that channel's word.
    always_comb begin
        gidx_s  = {SEL_W{1'b0}};
        gdata_s = {W{1'b0}};
        for (int i = 0; i < N_CH; i++) begin
            gidx_s  = gidx_s | (grant_s[i] ? SEL_W'(i) : {SEL_W{1'b0}});
            gdata_s = gdata_s | (in_data[i*W +: W] & {W{grant_s[i]}});
        end
    end

    // Output slot and rotation pointer; the pointer moves only on a transfer.
    always_ff @(posedge clk) begin
        if (rst) begin
            out_data_r  <= {W{1'b0}};
            out_ch_r    <= {SEL_W{1'b0}};
            out_valid_r <= 1'b0;
            ptr_r       <= {SEL_W{1'b0}};
        end else if (xfer_s) begin
            out_data_r  <= gdata_s;
            out_ch_r    <= gidx_s;
            out_valid_r <= 1'b1;
            ptr_r       <= (int'(gidx_s) == N_CH-1) ? {SEL_W{1'b0}} : gidx_s + SEL_W'(1);
        end else if (out_ready) begin
            out_valid_r <= 1'b0;
        end else begin
            out_valid_r <= out_valid_r;
        end
    end

    assign in_ready  = in_ready_s;
    assign out_data  = out_data_r;
    assign out_ch    = out_ch_r;
    assign out_valid = out_valid_r;

endmodule
